// File: rtl/branch_fwd_pkg.sv
// Shared types and constants for the ID-stage branch operand forwarding control.
// Used by branch_fwd_ctrl and branch_shadow_pipe.
package branch_fwd_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_RS1  = 2'b01;
   localparam logic [1:0] FWD_RS2  = 2'b10;

   localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

   // Destination info for one pipeline stage: index, writes-rd, is-load.
   typedef struct packed {
      logic [REG_ADDR_W_DEF-1:0] rd;
      logic                      wr;
      logic                      ld;
   } shadow_t;

   localparam shadow_t SHADOW_BUBBLE = '{rd: REG_ZERO, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/branch_shadow_pipe.sv
// Two-stage shadow of destination info for the EX and MEM stages.
// A bubble enters EX whenever ID does not advance.
module branch_shadow_pipe
   import branch_fwd_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    load_en,
   input  shadow_t id_info,
   output shadow_t ex_q,
   output shadow_t mem_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= SHADOW_BUBBLE;
         mem_q <= SHADOW_BUBBLE;
      end else begin
         mem_q <= ex_q;
         ex_q  <= load_en ? id_info : SHADOW_BUBBLE;
      end
   end

endmodule

// File: rtl/branch_fwd_ctrl.sv
// Branch operand forward/stall/flush control for the ID-stage comparator.
// Optional perf counters enabled by defining BRANCH_FWD_PERF_EN.
module branch_fwd_ctrl
   import branch_fwd_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int PERF_CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_is_branch,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  branch_taken,
   output logic [1:0]            fwd_sel,
   output logic                  stall,
   output logic                  flush_if
`ifdef BRANCH_FWD_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_stall_cnt,
   output logic [PERF_CNT_W-1:0] perf_fwd_cnt
`endif
);

   shadow_t id_info;
   shadow_t ex_q;
   shadow_t mem_q;
   logic    is_branch;
   logic    hit_ex1, hit_ex2, hit_mem1, hit_mem2;

   always_comb begin
      id_info = '{rd: id_rd, wr: id_reg_write, ld: id_mem_read};
   end

   branch_shadow_pipe u_shadow (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (id_valid && !stall),
      .id_info (id_info),
      .ex_q    (ex_q),
      .mem_q   (mem_q)
   );

   assign is_branch = id_valid && id_is_branch;

   assign hit_ex1  = ex_q.wr  && (ex_q.rd  == id_rs1) && (id_rs1 != REG_ZERO);
   assign hit_ex2  = ex_q.wr  && (ex_q.rd  == id_rs2) && (id_rs2 != REG_ZERO);
   assign hit_mem1 = mem_q.wr && (mem_q.rd == id_rs1) && (id_rs1 != REG_ZERO);
   assign hit_mem2 = mem_q.wr && (mem_q.rd == id_rs2) && (id_rs2 != REG_ZERO);

   // Only one forward path exists, and it is taken from MEM's ALU result.
   always_comb begin
      stall   = 1'b0;
      fwd_sel = FWD_NONE;
      if (is_branch) begin
         if (hit_ex1 || hit_ex2) begin
            stall = 1'b1;
         end else if ((hit_mem1 || hit_mem2) && mem_q.ld) begin
            stall = 1'b1;
         end else if (hit_mem1 && hit_mem2) begin
            stall = 1'b1;
         end else if (hit_mem1) begin
            fwd_sel = FWD_RS1;
         end else if (hit_mem2) begin
            fwd_sel = FWD_RS2;
         end
      end
   end

   assign flush_if = is_branch && !stall && branch_taken;

   // EX load-ness only matters once the entry has moved into MEM.
   logic unused_ex_ld;
   assign unused_ex_ld = ex_q.ld;

`ifdef BRANCH_FWD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else begin
         if (stall && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
         end
         if ((fwd_sel != FWD_NONE) && (perf_fwd_cnt != '1)) begin
            perf_fwd_cnt <= perf_fwd_cnt + PERF_CNT_W'(1);
         end
      end
   end
`else
   logic unused_perf_w;
   assign unused_perf_w = (PERF_CNT_W > 0);
`endif

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Bench for branch_fwd_ctrl: directed test-plan steps, async reset mid-stall,
// then a randomized run checked against a producer-age reference model.
module tb_branch_fwd_ctrl;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic       id_is_branch;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       branch_taken;
   logic [1:0] fwd_sel;
   logic       stall;
   logic       flush_if;
`ifdef BRANCH_FWD_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_fwd_cnt;
`endif

   int checks = 0;
   int errors = 0;

   branch_fwd_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_is_branch (id_is_branch),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .branch_taken (branch_taken),
      .fwd_sel      (fwd_sel),
      .stall        (stall),
      .flush_if     (flush_if)
`ifdef BRANCH_FWD_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_fwd_cnt   (perf_fwd_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: what entered EX one and two cycles ago
   typedef struct {
      bit wr;
      bit ld;
      int rd;
   } prod_t;

   prod_t hist_q[$];
   int    mdl_stall_cnt;
   int    mdl_fwd_cnt;
   logic [3:0] exp_q[$];

   function automatic void model_reset();
      prod_t b;
      b.wr = 0; b.ld = 0; b.rd = 0;
      hist_q.delete();
      hist_q.push_back(b);
      hist_q.push_back(b);
      mdl_stall_cnt = 0;
      mdl_fwd_cnt   = 0;
   endfunction

   // A producer of age 1 is in EX, age 2 in MEM; older ones come via the regfile.
   function automatic bit produced(input int age, input int r);
      return (r != 0) && hist_q[age-1].wr && (hist_q[age-1].rd == r);
   endfunction

   function automatic void model_eval(input bit v, input bit br, input int rs1, input int rs2,
                                      input bit tk, output bit s, output logic [1:0] f,
                                      output bit fl);
      bit m1, m2;
      s = 0;
      f = 2'b00;
      if (v && br) begin
         m1 = produced(2, rs1);
         m2 = produced(2, rs2);
         if (produced(1, rs1) || produced(1, rs2)) s = 1;
         else if ((m1 || m2) && hist_q[1].ld)      s = 1;
         else if (m1 && m2)                        s = 1;
         else if (m1)                              f = 2'b01;
         else if (m2)                              f = 2'b10;
      end
      fl = v && br && !s && tk;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one ID instruction for one cycle. Directed steps compare against the
   // given constants; random steps compare against the model through exp_q.
   task automatic do_cycle(input string tag, input bit v, input bit br, input int rs1,
                           input int rs2, input int rd, input bit wr, input bit ld,
                           input bit tk, input bit directed, input bit d_stall,
                           input logic [1:0] d_fwd, input bit d_flush);
      bit         m_s, m_fl;
      logic [1:0] m_f;
      logic [3:0] e;
      prod_t      p;
      id_valid     = v;
      id_is_branch = br;
      id_rs1       = rs1[4:0];
      id_rs2       = rs2[4:0];
      id_rd        = rd[4:0];
      id_reg_write = wr;
      id_mem_read  = ld;
      branch_taken = tk;
      #1;
      model_eval(v, br, rs1, rs2, tk, m_s, m_f, m_fl);
      if (directed) begin
         chk({tag, ".stall"}, 32'(stall), 32'(d_stall));
         chk({tag, ".fwd_sel"}, 32'(fwd_sel), 32'(d_fwd));
         chk({tag, ".flush_if"}, 32'(flush_if), 32'(d_flush));
      end else begin
         exp_q.push_back({m_s, m_f, m_fl});
         e = exp_q.pop_front();
         chk({tag, ".outs"}, 32'({stall, fwd_sel, flush_if}), 32'(e));
      end
      if (m_s) mdl_stall_cnt++;
      if (m_f != 2'b00) mdl_fwd_cnt++;
      @(posedge clk);
      p.wr = v && !m_s && wr;
      p.ld = v && !m_s && ld;
      p.rd = (v && !m_s) ? rd : 0;
      hist_q.push_front(p);
      void'(hist_q.pop_back());
      #2;
   endtask

   task automatic nop(input string tag);
      do_cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
   endtask

`ifdef BRANCH_FWD_PERF_EN
   task automatic chk_perf(input string tag);
      #1;
      chk({tag, ".perf_stall"}, perf_stall_cnt, 32'(mdl_stall_cnt));
      chk({tag, ".perf_fwd"}, perf_fwd_cnt, 32'(mdl_fwd_cnt));
   endtask
`endif

   initial begin
      bit v, br, wr, ld, tk, last_stall;
      int rs1, rs2, rd;

      rst_n = 0;
      id_valid = 0; id_is_branch = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_reg_write = 0; id_mem_read = 0; branch_taken = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.stall", 32'(stall), 0);
      chk("reset.fwd_sel", 32'(fwd_sel), 0);
      chk("reset.flush_if", 32'(flush_if), 0);
`ifdef BRANCH_FWD_PERF_EN
      chk_perf("reset");
`endif
      rst_n = 1;
      @(posedge clk);
      #2;

      // ALU producer in MEM: forward to read1, taken branch flushes once
      do_cycle("mem_fwd.addi", 1, 0, 0, 0, 5, 1, 0, 0, 1, 0, 2'b00, 0);
      nop("mem_fwd.gap");
      do_cycle("mem_fwd.beq", 1, 1, 5, 6, 0, 0, 0, 1, 1, 0, 2'b01, 1);
      nop("mem_fwd.after");

      // ALU producer in EX: one stall cycle, then forward to read2
      do_cycle("ex_alu.add", 1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 2'b00, 0);
      do_cycle("ex_alu.bne0", 1, 1, 1, 7, 0, 0, 0, 1, 1, 1, 2'b00, 0);
      do_cycle("ex_alu.bne1", 1, 1, 1, 7, 0, 0, 0, 0, 1, 0, 2'b10, 0);

      // Load in EX: two stall cycles, then value comes from the regfile
      do_cycle("ex_ld.lw", 1, 0, 2, 0, 3, 1, 1, 0, 1, 0, 2'b00, 0);
      do_cycle("ex_ld.beq0", 1, 1, 3, 0, 0, 0, 0, 1, 1, 1, 2'b00, 0);
      do_cycle("ex_ld.beq1", 1, 1, 3, 0, 0, 0, 0, 1, 1, 1, 2'b00, 0);
      do_cycle("ex_ld.beq2", 1, 1, 3, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1);

      // Both operands hit MEM: one stall cycle
      do_cycle("dbl.add", 1, 0, 0, 0, 4, 1, 0, 0, 1, 0, 2'b00, 0);
      nop("dbl.gap");
      do_cycle("dbl.beq0", 1, 1, 4, 4, 0, 0, 0, 0, 1, 1, 2'b00, 0);
      do_cycle("dbl.beq1", 1, 1, 4, 4, 0, 0, 0, 0, 1, 0, 2'b00, 0);

      // x0 is never a hazard; non-branches never stall
      do_cycle("x0.addi", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0);
      do_cycle("x0.beq", 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1);
      do_cycle("nb.add", 1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 2'b00, 0);
      do_cycle("nb.sub", 1, 0, 2, 2, 2, 1, 0, 1, 1, 0, 2'b00, 0);

      // Asynchronous reset in the middle of a load stall
      do_cycle("rst.lw", 1, 0, 0, 0, 3, 1, 1, 0, 1, 0, 2'b00, 0);
      id_valid = 1; id_is_branch = 1; id_rs1 = 5'd3; id_rs2 = 5'd0;
      id_rd = 0; id_reg_write = 0; id_mem_read = 0; branch_taken = 0;
      #1;
      chk("rst.pre_stall", 32'(stall), 1);
      rst_n = 0;
      #1;
      chk("rst.stall_drop", 32'(stall), 0);
      chk("rst.fwd_sel", 32'(fwd_sel), 0);
      model_reset();
`ifdef BRANCH_FWD_PERF_EN
      chk_perf("rst.perf");
`endif
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #2;
      do_cycle("rst.shadow_clear", 1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0);

      // Load stall sequence plus one forward, for the counters
      do_cycle("cnt.lw", 1, 0, 0, 0, 3, 1, 1, 0, 1, 0, 2'b00, 0);
      do_cycle("cnt.beq0", 1, 1, 3, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0);
      do_cycle("cnt.beq1", 1, 1, 3, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0);
      do_cycle("cnt.beq2", 1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
      do_cycle("cnt.addi", 1, 0, 0, 0, 9, 1, 0, 0, 1, 0, 2'b00, 0);
      nop("cnt.gap");
      do_cycle("cnt.beq3", 1, 1, 9, 1, 0, 0, 0, 0, 1, 0, 2'b01, 0);
`ifdef BRANCH_FWD_PERF_EN
      chk("cnt.total", perf_stall_cnt + perf_fwd_cnt, 32'd3);
      chk_perf("cnt");
`endif

      // Randomized run; a stalled instruction is held in ID like the real pipe
      last_stall = 0;
      v = 0; br = 0; rs1 = 0; rs2 = 0; rd = 0; wr = 0; ld = 0;
      for (int n = 0; n < 400; n++) begin
         if (!last_stall) begin
            v   = ($urandom_range(0, 9) != 0);
            br  = ($urandom_range(0, 1) == 1);
            rs1 = $urandom_range(0, 3);
            rs2 = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            wr  = !br && ($urandom_range(0, 4) != 0);
            ld  = wr && ($urandom_range(0, 2) == 0);
         end
         tk = ($urandom_range(0, 1) == 1);
         do_cycle("rand", v, br, rs1, rs2, rd, wr, ld, tk, 0, 0, 2'b00, 0);
         last_stall = stall;
      end
`ifdef BRANCH_FWD_PERF_EN
      chk_perf("rand");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
